// File: rtl/tt_um_swisschips_uart_tx.sv
// -----------------------------------------------------------------------------
// tt_um_swisschips_uart_tx
//
// Byte-serialising UART transmitter (8N1) packaged as a TinyTapeout user
// project. Bytes presented on ui_in are enqueued on a rising edge of the write
// strobe into a 4-entry FIFO. They are then shifted out LSB first on
// uo_out[0]. Each frame is one start bit, eight data bits and one stop bit, and
// every bit lasts CLKS_PER_BIT clocks. When the FIFO still holds data at the end
// of a stop bit, the next start bit follows immediately.
//
// Ports
//   clk      : system clock
//   rst_n    : synchronous, active-low reset
//   ena      : TinyTapeout enable (not used; the design always runs)
//   ui_in    : data byte to enqueue
//   uio_in   : [0] write strobe (rising edge pushes), [1] overflow clear,
//              [7:2] unused
//   uo_out   : [0] txd, [1] busy, [2] fifo_full, [3] fifo_empty,
//              [4] overflow (sticky), [7:5] fifo count (0..4)
//   uio_out  : constant 0
//   uio_oe   : constant 0 (all bidirectional pins are inputs)
//
// All of uo_out comes from one register. Its next value is computed from the
// next-state logic, so no input reaches an output without passing a register.
// -----------------------------------------------------------------------------
module tt_um_swisschips_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [2:0] FIFO_DEPTH = 3'd4;

    // Advance a FIFO pointer; the 2-bit width gives the modulo-4 wrap.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return ptr + 2'd1;
    endfunction

    // Build the status byte in uo_out bit order.
    function automatic logic [7:0] status_byte(
        input logic [2:0] count,
        input logic       overflow,
        input logic [1:0] state,
        input logic       txd
    );
        return {count, overflow, (count == 3'd0), (count == FIFO_DEPTH),
                (state != ST_IDLE), txd};
    endfunction

    // ---------------------------------------------------------------- state
    logic [1:0]    state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic [7:0]    mem_r [4];
    logic [1:0]    wr_ptr_r;
    logic [1:0]    rd_ptr_r;
    logic [2:0]    count_r;
    logic          overflow_r;
    logic          wr_q_r;
    logic [7:0]    uo_out_r;

    // ---------------------------------------------------------- next values
    logic [1:0]    state_s;
    logic [TW-1:0] timer_s;
    logic [2:0]    bit_idx_s;
    logic [7:0]    shift_s;
    logic          pop_s;
    logic          push_s;
    logic          push_ok_s;
    logic          ovf_set_s;
    logic [2:0]    count_s;
    logic [1:0]    wr_ptr_s;
    logic [1:0]    rd_ptr_s;
    logic          overflow_s;
    logic          txd_s;
    logic          fifo_has_data_s;
    logic          bit_done_s;

    // ena and the spare uio inputs are deliberately ignored.
    logic unused_inputs_s;
    assign unused_inputs_s = ^{ena, uio_in[7:2]};

    assign fifo_has_data_s = (count_r != 3'd0);
    assign bit_done_s      = (timer_r == TIMER_LAST);

    // Transmit FSM: bit timing, shifting and FIFO pop requests.
    always_comb begin
        state_s   = state_r;
        timer_s   = timer_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fifo_has_data_s) begin
                    pop_s   = 1'b1;
                    shift_s = mem_r[rd_ptr_r];
                    timer_s = TIMER_ZERO;
                    state_s = ST_START;
                end else begin
                    timer_s = TIMER_ZERO;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    timer_s   = TIMER_ZERO;
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    timer_s = TIMER_ZERO;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        shift_s   = {1'b0, shift_r[7:1]};
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    timer_s = TIMER_ZERO;
                    // Chain straight into the next start bit when data waits.
                    if (fifo_has_data_s) begin
                        pop_s   = 1'b1;
                        shift_s = mem_r[rd_ptr_r];
                        state_s = ST_START;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = TIMER_ZERO;
            end
        endcase
    end

    // FIFO bookkeeping: push acceptance, count, pointers and overflow flag.
    always_comb begin
        push_s    = uio_in[0] & ~wr_q_r;
        // A full FIFO still accepts a push when a pop frees a slot on the same edge.
        push_ok_s = push_s & ((count_r != FIFO_DEPTH) | pop_s);
        ovf_set_s = push_s & ~push_ok_s;
        case ({push_ok_s, pop_s})
            2'b10:   count_s = count_r + 3'd1;
            2'b01:   count_s = count_r - 3'd1;
            default: count_s = count_r;
        endcase
        if (push_ok_s) begin
            wr_ptr_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        // Setting has priority over clearing when both happen on one edge.
        if (ovf_set_s) begin
            overflow_s = 1'b1;
        end else if (uio_in[1]) begin
            overflow_s = 1'b0;
        end else begin
            overflow_s = overflow_r;
        end
    end

    // Line level implied by the state being entered.
    always_comb begin
        case (state_s)
            ST_IDLE:  txd_s = 1'b1;
            ST_START: txd_s = 1'b0;
            ST_DATA:  txd_s = shift_s[0];
            ST_STOP:  txd_s = 1'b1;
            default:  txd_s = 1'b1;
        endcase
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            timer_r    <= TIMER_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            wr_ptr_r   <= 2'd0;
            rd_ptr_r   <= 2'd0;
            count_r    <= 3'd0;
            overflow_r <= 1'b0;
            wr_q_r     <= 1'b0;
            uo_out_r   <= status_byte(3'd0, 1'b0, ST_IDLE, 1'b1);
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            wr_ptr_r   <= wr_ptr_s;
            rd_ptr_r   <= rd_ptr_s;
            count_r    <= count_s;
            overflow_r <= overflow_s;
            wr_q_r     <= uio_in[0];
            uo_out_r   <= status_byte(count_s, overflow_s, state_s, txd_s);
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok_s) begin
            mem_r[wr_ptr_r] <= ui_in;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    assign uo_out  = uo_out_r;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_swisschips_uart_tx.sv
// -----------------------------------------------------------------------------
// Testbench for tt_um_swisschips_uart_tx.
// Stimulus is driven on the falling edge. A frame-level reference model steps on
// each rising edge. It keeps the buffered bytes in a queue, tracks the current
// frame as a countdown of cycles, and predicts the status byte. Accepted bytes
// are pushed to a scoreboard. A separate monitor checks uo_out every cycle,
// decodes txd as a UART receiver, and pops the scoreboard for every frame it
// receives.
// -----------------------------------------------------------------------------
module tb_tt_um_swisschips_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    tt_um_swisschips_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] mq[$];          // bytes waiting in the FIFO
    logic [7:0] sb[$];          // scoreboard: accepted bytes not yet received
    int         frame_left = 0; // cycles left in the frame on the line (0 = idle)
    logic [7:0] cur_byte = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_wrq = 1'b0;
    logic       m_rst_flag = 1'b0;
    logic       model_valid = 1'b0;
    logic [7:0] exp_uo = 8'h09;
    logic       rx_active = 1'b0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_txd();
        int pos;
        int b;
        if (frame_left == 0) return 1'b1;
        pos = FRAME - frame_left;
        b   = pos / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cur_byte[b-1];
    endfunction

    task automatic model_step(input logic r, input logic w, input logic c, input logic [7:0] d);
        int  size_before;
        logic push;
        logic pop;
        logic accept;
        if (!r) begin
            mq.delete();
            sb.delete();
            frame_left = 0;
            m_ovf      = 1'b0;
            m_wrq      = 1'b0;
            m_rst_flag = 1'b1;
        end else begin
            m_rst_flag  = 1'b0;
            size_before = mq.size();
            push        = w && !m_wrq;
            pop         = (frame_left <= 1) && (size_before > 0);
            accept      = push && ((size_before < 4) || pop);
            if (pop) begin
                cur_byte   = mq.pop_front();
                frame_left = FRAME;
            end else if (frame_left > 0) begin
                frame_left--;
            end
            if (accept) begin
                mq.push_back(d);
                sb.push_back(d);
            end
            if (push && !accept) m_ovf = 1'b1;
            else if (c)          m_ovf = 1'b0;
            m_wrq = w;
        end
        exp_uo = {3'(mq.size()), m_ovf, (mq.size() == 0), (mq.size() == 4),
                  (frame_left != 0), model_txd()};
        model_valid = 1'b1;
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge.
    task automatic cyc(input logic r, input logic w, input logic c, input logic [7:0] d);
        logic [5:0] junk;
        junk   = 6'($urandom);
        rst_n  = r;
        uio_in = {junk, c, w};
        ui_in  = d;
        ena    = 1'($urandom);
        @(posedge clk);
        model_step(r, w, c, d);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic drain(input int max_cycles);
        int k;
        k = 0;
        while ((frame_left != 0 || mq.size() != 0) && k < max_cycles) begin
            cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
            k++;
        end
        check8("drain_idle", {7'd0, (frame_left == 0 && mq.size() == 0)}, 8'h01);
        idle(3);
    endtask

    // Monitor: per-cycle status compare plus UART frame receiver.
    initial begin : monitor
        int         rx_cnt;
        int         b;
        logic [7:0] rx_byte;
        logic [7:0] e;
        rx_cnt  = 0;
        rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            if (model_valid) begin
                check8("uo_out", uo_out, exp_uo);
                check8("uio_out", uio_out, 8'h00);
                check8("uio_oe", uio_oe, 8'h00);
                if (m_rst_flag) begin
                    rx_active = 1'b0;
                end else begin
                    if (!rx_active && uo_out[0] == 1'b0) begin
                        rx_active = 1'b1;
                        rx_cnt    = 0;
                    end
                    if (rx_active) begin
                        if (rx_cnt % CPB == CPB / 2) begin
                            b = rx_cnt / CPB;
                            if (b == 0) begin
                                check8("start_bit", {7'd0, uo_out[0]}, 8'h00);
                            end else if (b <= 8) begin
                                rx_byte[b-1] = uo_out[0];
                            end else begin
                                check8("stop_bit", {7'd0, uo_out[0]}, 8'h01);
                                if (sb.size() == 0) begin
                                    n_checks++;
                                    n_fail++;
                                    $display("FAIL unexpected_frame: got 0x%02h expected no frame at %0t",
                                             rx_byte, $time);
                                end else begin
                                    e = sb.pop_front();
                                    check8("rx_byte", rx_byte, e);
                                end
                                rx_active = 1'b0;
                            end
                        end
                        rx_cnt++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(negedge clk);

        // 1. Reset with random inputs
        cyc(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
        cyc(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
        check8("reset_uo_out", uo_out, 8'h09);
        check8("reset_uio_oe", uio_oe, 8'h00);
        check8("reset_uio_out", uio_out, 8'h00);
        idle(3);

        // 2. Single byte 0xA5
        cyc(1'b1, 1'b1, 1'b0, 8'hA5);
        check8("push_latency_count", uo_out, 8'h21);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        check8("pop_start_bit", uo_out, 8'h0A);
        idle(45);
        check8("single_done", uo_out, 8'h09);

        // 3. Back-to-back 0x00 then 0xFF
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'hFF);
        idle(90);
        check8("b2b_done", uo_out, 8'h09);

        // 4. Overflow: six pushes with 2-cycle spacing
        for (int i = 1; i <= 6; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(i));
            cyc(1'b1, 1'b0, 1'b0, 8'($urandom));
        end
        check8("overflow_status", {2'b00, uo_out[7:2]}, 8'h25);
        cyc(1'b1, 1'b0, 1'b1, 8'($urandom));
        check8("overflow_cleared", {7'd0, uo_out[4]}, 8'h00);
        drain(300);

        // 5. Reset during data bit 3 of a 0x00 frame with two bytes queued
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'hAA);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h55);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        idle(13);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        check8("midframe_reset", uo_out, 8'h09);
        idle(100);
        check8("midframe_no_frames", uo_out, 8'h09);

        // 6. Held strobe
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'h3C);
            check8("held_count_le1", {7'd0, (uo_out[7:5] <= 3'd1)}, 8'h01);
        end
        idle(60);
        check8("held_done", uo_out, 8'h09);

        // 7. Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 499) != 0),
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 15) == 0),
                8'($urandom));
        end
        drain(400);

        check8("scoreboard_empty", 8'(sb.size()), 8'h00);
        check8("receiver_idle", {7'd0, rx_active}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
